program_loader: RTL and testbench
=================================

// Module: program_loader
//
// PURPOSE
//  Drives the single-cycle DataPath from the other end of the program interface.
//  It accepts a byte stream, packs bytes into 32-bit words and writes them into
//  instruction memory. While loading, it holds the CPU in reset. It then releases
//  the CPU for a fixed cycle budget and halts it again.
//
// PARAMETERS
//  WORDS       64  instruction memory capacity in 32-bit words (power of 2, >=2)
//  RUN_CYCLES  20  CPU clock cycles allowed in RUN before forced halt (>=1)
//  CW          $clog2(WORDS)+1  width of wordCount (derived, localparam)
//
// PORTS
//  clock       in   1   single system clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  start       in   1   one-cycle pulse; begins a load (honoured only in IDLE)
//  byteIn      in   8   program byte, big-endian within each word
//  byteValid   in   1   byteIn valid this cycle
//  byteLast    in   1   qualifies final byte of program (valid with byteValid)
//  byteReady   out  1   loader accepts byte this cycle
//  imemWe      out  1   instruction memory write strobe (one cycle per word)
//  imemAddr    out  32  byte address of the word written, = index*4
//  imemWData   out  32  word written
//  cpuReset    out  1   reset to DataPath; 1 except in RUN
//  running     out  1   1 while in RUN
//  halted      out  1   1 while in HALT
//  overflow    out  1   sticky: more than WORDS words offered
//  wordCount   out  CW  words written since start
//  clockCount  out  32  RUN cycles elapsed
//
// BEHAVIOUR
//  Reset (any state, mid-word included): state IDLE. All outputs 0 except
//  cpuReset=1. The partial word and all counters are discarded.
//  States: IDLE -> LOAD -> WRITE -> (LOAD | RUN) ; RUN -> HALT ; HALT holds.
//  IDLE: byteReady=0. start=1 -> LOAD; clear wordCount, clockCount, overflow.
//  LOAD: byteReady=1. byteValid&byteReady accepts a byte.
//  - Byte k (k=0..3) lands in bits [31-8k -: 8]; byte 0 is the MSB.
//  - On accepting byte 3, or a byte with byteLast=1, go to WRITE.
//  - A short last word has its unfilled low bytes set to 0.
//  WRITE (exactly 1 cycle): byteReady=0, imemWe=1, imemAddr=wordCount*4,
//  imemWData=packed word. wordCount increments on the following edge.
//  - Next state RUN if last seen, or if wordCount+1==WORDS.
//  - Otherwise next state LOAD, with the byte index reset to 0.
//  - If WORDS is reached without last, set overflow=1. Later bytes get
//    byteReady=0 and are never written.
//  Latency: a word's write strobe is asserted in the cycle after its 4th
//  accepted byte. Peak throughput is 4 bytes per 5 cycles.
//  RUN: cpuReset=0, running=1, clockCount+1 every cycle.
//  - Go to HALT on the edge where clockCount==RUN_CYCLES-1, so the CPU gets
//    exactly RUN_CYCLES un-reset cycles.
//  HALT: cpuReset=1, halted=1, clockCount frozen. Only reset leaves HALT.
//  Edge cases:
//  - start outside IDLE is ignored.
//  - byteValid outside LOAD is ignored and not consumed.
//  - byteLast without byteValid is ignored.
//  - imemWe is never asserted outside WRITE.
//  - wordCount never exceeds WORDS.
//  - Address width: imemAddr = {zero-extend(index), 2'b00}.
//
// STRUCTURE
//  cpu_pkg: typedef enum logic [2:0] {IDLE,LOAD,WRITE,RUN,HALT} loader_state_t;
//  WORD_BYTES=4.
//  Sub-module word_assembler holds the byte index, the shift/pack logic,
//  zero-fill and a wordDone flag. It has its own clear input. The FSM and
//  counters live in program_loader.
//
// TESTING
//  1. Reset held 2 cycles -> cpuReset=1, byteReady=0, imemWe=0, counts 0.
//  2. Load bytes 20 08 00 05 with last on byte 4 -> one imemWe, addr 0,
//     data 32'h20080005, then RUN.
//  3. Load 8 bytes, stall byteValid 3 cycles mid-word -> words at addr 0 and
//     4, wordCount=2.
//  4. Load 6 bytes AA BB CC DD 11 22 with last ->
//     second word 32'h11220000 at addr 4.
//  5. RUN_CYCLES=20 -> cpuReset low exactly 20 cycles, then halted=1,
//     clockCount=20. Pulse start in HALT -> no change.
//  6. WORDS=4, offer 5 words -> 4 writes (addr 0..12), overflow=1, RUN.
//     Reset mid-word during a reload -> IDLE, partial word never written.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the program loader.
// Loader FSM states and packing constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN,
    HALT
  } loader_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// Byte 0 lands in the MSB; a short last word is zero-filled.
module word_assembler
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_done,
  output logic        o_last,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic        r_last;
  logic        w_done;
  logic [31:0] w_lane;

  assign w_done = i_accept &
    ((r_idx == 2'(WORD_BYTES - 1)) | i_last);
  assign w_lane = {i_byte, 24'h0} >> {r_idx, 3'b000};

  // Byte 0 restarts the word so unfilled lanes read as zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
      r_last <= 1'b0;
    end else if (i_accept) begin
      r_word <= (r_idx == 2'd0) ? w_lane : (r_word | w_lane);
      r_idx  <= w_done ? 2'd0 : r_idx + 2'd1;
      if (i_last) r_last <= 1'b1;
    end
  end

  assign o_done = w_done;
  assign o_last = r_last;
  assign o_word = r_word;

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory, then runs
// the CPU for a fixed cycle budget and halts it.
module program_loader
  import cpu_pkg::*;
#(
  parameter int WORDS      = 64,
  parameter int RUN_CYCLES = 20,
  localparam int CW        = $clog2(WORDS) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    byteIn,
  input  logic          byteValid,
  input  logic          byteLast,
  output logic          byteReady,
  output logic          imemWe,
  output logic [31:0]   imemAddr,
  output logic [31:0]   imemWData,
  output logic          cpuReset,
  output logic          running,
  output logic          halted,
  output logic          overflow,
  output logic [CW-1:0] wordCount,
  output logic [31:0]   clockCount
);

  loader_state_t r_state, w_next;
  logic [CW-1:0] r_word_count;
  logic [31:0]   r_clock_count;
  logic          r_overflow;
  logic          w_accept;
  logic          w_clear;
  logic          w_done;
  logic          w_last;
  logic          w_full;
  logic          w_budget;
  logic [31:0]   w_word;

  assign w_accept = byteValid & byteReady;
  assign w_clear  = (r_state == IDLE) & start;
  assign w_full   = (r_word_count + CW'(1)) == CW'(WORDS);
  assign w_budget = r_clock_count == 32'(RUN_CYCLES - 1);

  word_assembler u_asm (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_byte   (byteIn),
    .i_last   (byteLast),
    .o_done   (w_done),
    .o_last   (w_last),
    .o_word   (w_word)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-state outputs.
  always_comb begin
    w_next    = r_state;
    byteReady = 1'b0;
    imemWe    = 1'b0;
    cpuReset  = 1'b1;
    running   = 1'b0;
    halted    = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        byteReady = 1'b1;
        if (w_done) w_next = WRITE;
      end
      WRITE: begin
        imemWe = 1'b1;
        w_next = (w_last || w_full) ? RUN : LOAD;
      end
      RUN: begin
        cpuReset = 1'b0;
        running  = 1'b1;
        if (w_budget) w_next = HALT;
      end
      HALT: halted = 1'b1;
      default: w_next = IDLE;
    endcase
  end

  // Word/cycle counters and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_count  <= '0;
      r_clock_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_clear) begin
        r_word_count  <= '0;
        r_clock_count <= '0;
        r_overflow    <= 1'b0;
      end
      if (r_state == WRITE) begin
        r_word_count <= r_word_count + CW'(1);
        if (w_full && !w_last) r_overflow <= 1'b1;
      end
      if (r_state == RUN)
        r_clock_count <= r_clock_count + 32'd1;
    end
  end

  assign imemAddr   = {{(30-CW){1'b0}}, r_word_count, 2'b00};
  assign imemWData  = w_word;
  assign overflow   = r_overflow;
  assign wordCount  = r_word_count;
  assign clockCount = r_clock_count;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader.
// Expected writes are queued as bytes are driven.
module tb_program_loader;

  localparam int WORDS      = 4;
  localparam int RUN_CYCLES = 20;
  localparam int CW         = $clog2(WORDS) + 1;

  logic          clock;
  logic          reset;
  logic          start;
  logic [7:0]    byteIn;
  logic          byteValid;
  logic          byteLast;
  logic          byteReady;
  logic          imemWe;
  logic [31:0]   imemAddr;
  logic [31:0]   imemWData;
  logic          cpuReset;
  logic          running;
  logic          halted;
  logic          overflow;
  logic [CW-1:0] wordCount;
  logic [31:0]   clockCount;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  logic [63:0] sb[$];

  program_loader #(
    .WORDS      (WORDS),
    .RUN_CYCLES (RUN_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byteIn     (byteIn),
    .byteValid  (byteValid),
    .byteLast   (byteLast),
    .byteReady  (byteReady),
    .imemWe     (imemWe),
    .imemAddr   (imemAddr),
    .imemWData  (imemWData),
    .cpuReset   (cpuReset),
    .running    (running),
    .halted     (halted),
    .overflow   (overflow),
    .wordCount  (wordCount),
    .clockCount (clockCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest queued word.
  always @(negedge clock) begin
    if (imemWe === 1'b1) begin
      logic [63:0] e;
      n_wr++;
      chk("wr_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", imemAddr, e[63:32]);
        chk("wr_data", imemWData, e[31:0]);
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a,
                           input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic last);
    int n;
    n = 0;
    byteIn    = b;
    byteValid = 1'b1;
    byteLast  = last;
    @(negedge clock);
    while (!byteReady && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("byte_rdy", 32'(byteReady), 32'd1);
    @(posedge clock);
    #1 byteValid = 1'b0;
    byteLast = 1'b0;
  endtask

  task automatic wait_running();
    int n;
    n = 0;
    while (running !== 1'b1 && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("run_reached", 32'(running), 32'd1);
  endtask

  initial begin
    int cnt;
    int n;
    logic [31:0] w;
    reset     = 1'b1;
    start     = 1'b0;
    byteIn    = 8'h0;
    byteValid = 1'b0;
    byteLast  = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cpuReset", 32'(cpuReset), 32'd1);
    chk("rst_byteReady", 32'(byteReady), 32'd0);
    chk("rst_imemWe", 32'(imemWe), 32'd0);
    chk("rst_wordCount", 32'(wordCount), 32'd0);
    chk("rst_clockCount", clockCount, 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // 2: single word with last on byte 4
    pulse_start();
    expect_wr(32'd0, 32'h2008_0005);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b1);
    @(negedge clock);
    chk("t2_we_latency", 32'(imemWe), 32'd1);
    wait_running();
    chk("t2_wordCount", 32'(wordCount), 32'd1);

    // 5: run budget then halt; start ignored in HALT
    cnt = 0;
    n = 0;
    while (halted !== 1'b1 && n < 100) begin
      if (cpuReset === 1'b0) cnt++;
      n++;
      @(negedge clock);
    end
    chk("t5_run_cycles", 32'(cnt), 32'd20);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_cpuReset", 32'(cpuReset), 32'd1);
    chk("t5_clockCount", clockCount, 32'd20);
    pulse_start();
    repeat (3) @(negedge clock);
    chk("t5_halt_hold", 32'(halted), 32'd1);
    chk("t5_clk_frozen", clockCount, 32'd20);
    chk("t5_wc_kept", 32'(wordCount), 32'd1);
    chk("t5_no_ready", 32'(byteReady), 32'd0);

    // 3: two words with a mid-word stall
    pulse_reset();
    pulse_start();
    expect_wr(32'd0, 32'h0102_0304);
    expect_wr(32'd4, 32'h0506_0708);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h08, 1'b1);
    @(negedge clock);
    wait_running();
    chk("t3_wordCount", 32'(wordCount), 32'd2);
    chk("t3_overflow", 32'(overflow), 32'd0);

    // 4: short last word zero-filled
    pulse_reset();
    pulse_start();
    expect_wr(32'd0, 32'hAABB_CCDD);
    expect_wr(32'd4, 32'h1122_0000);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    @(negedge clock);
    wait_running();
    chk("t4_wordCount", 32'(wordCount), 32'd2);

    // 6: overflow at WORDS=4
    pulse_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      w = 32'h1011_1213 + 32'(i) * 32'h0404_0404;
      expect_wr(32'(i * 4), w);
    end
    for (int i = 0; i < 16; i++)
      send_byte(8'(8'h10 + i), 1'b0);
    byteIn    = 8'hEE;
    byteValid = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6_no_ready", 32'(byteReady), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd1);
    chk("t6_wordCount", 32'(wordCount), 32'd4);
    chk("t6_running", 32'(running), 32'd1);
    @(posedge clock); #1 byteValid = 1'b0;

    // 6b: reset mid-word on reload discards partial word
    pulse_reset();
    pulse_start();
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t6b_wordCount", 32'(wordCount), 32'd0);
    chk("t6b_overflow", 32'(overflow), 32'd0);
    chk("t6b_cpuReset", 32'(cpuReset), 32'd1);
    chk("t6b_byteReady", 32'(byteReady), 32'd0);
    pulse_start();
    expect_wr(32'd0, 32'h7700_0000);
    send_byte(8'h77, 1'b1);
    @(negedge clock);
    wait_running();
    chk("t6b_wordCount2", 32'(wordCount), 32'd1);

    repeat (2) @(negedge clock);
    chk("total_writes", 32'(n_wr), 32'd10);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
